// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with refractory period.
// Define LIF_INHIBIT_EN to add the edge-detected inhibitory input inh_spike_in.
module lif_neuron #(
    parameter int N_IN          = 4,
    parameter int W_WIDTH       = 4,
    parameter int V_WIDTH       = 8,
    parameter int THRESHOLD     = 64,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRAC_CYCLES = 4,
    parameter int INH_WEIGHT    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [N_IN-1:0]           spike_in,
    input  logic [N_IN*W_WIDTH-1:0]   weight_in,
`ifdef LIF_INHIBIT_EN
    input  logic                      inh_spike_in,
`endif
    output logic                      spike_out,
    output logic [V_WIDTH-1:0]        membrane,
    output logic                      refractory,
    output logic [7:0]                spike_count
);
    localparam logic [0:0] S_INT = 1'b0;
    localparam logic [0:0] S_REF = 1'b1;
    localparam int RW = REFRAC_CYCLES > 1 ? $clog2(REFRAC_CYCLES) : 1;
    localparam int SW = V_WIDTH + 2;
    localparam int TW = V_WIDTH + 4;
    localparam logic signed [TW-1:0] VMAX = {{(TW-V_WIDTH){1'b0}}, {V_WIDTH{1'b1}}};

    logic [N_IN-1:0]    prev_q;
    logic [0:0]         state_q, state_d;
    logic [RW-1:0]      rcnt_q, rcnt_d;
    logic [V_WIDTH-1:0] v_q, v_d, v_leak, t_sat;
    logic               spk_q, spk_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [N_IN-1:0]    ev;
    logic [SW-1:0]      sum;
    logic [TW-1:0]      inh_term;
    logic signed [TW-1:0] t_raw;
    logic               fire;

    assign ev = spike_in & ~prev_q;

`ifdef LIF_INHIBIT_EN
    logic inh_prev_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) inh_prev_q <= 1'b0;
        else        inh_prev_q <= inh_spike_in;
    assign inh_term = (inh_spike_in & ~inh_prev_q) ? TW'(INH_WEIGHT) : '0;
`else
    assign inh_term = '0;
`endif

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++)
            sum = sum + (ev[i] ? SW'(weight_in[i*W_WIDTH +: W_WIDTH]) : SW'(0));
    end

    // Signed intermediate so an inhibitory decrement can clamp at zero.
    assign v_leak = v_q - (v_q >> LEAK_SHIFT);
    assign t_raw  = $signed({4'b0, v_leak}) + $signed({2'b0, sum}) - $signed(inh_term);
    assign t_sat  = t_raw < 0 ? '0 : t_raw > VMAX ? '1 : t_raw[V_WIDTH-1:0];
    assign fire   = t_sat >= V_WIDTH'(THRESHOLD);

    always_comb begin
        v_d     = v_q;
        state_d = state_q;
        rcnt_d  = rcnt_q;
        spk_d   = 1'b0;
        cnt_d   = cnt_q;
        if (ena) begin
            if (state_q == S_REF) begin
                v_d = '0;
                if (rcnt_q == '0) state_d = S_INT;
                else              rcnt_d  = rcnt_q - RW'(1);
            end else if (fire) begin
                v_d   = '0;
                spk_d = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (REFRAC_CYCLES != 0) begin
                    state_d = S_REF;
                    rcnt_d  = RW'(REFRAC_CYCLES - 1);
                end
            end else begin
                v_d = t_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            state_q <= S_INT;
            rcnt_q  <= '0;
            v_q     <= '0;
            spk_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            prev_q  <= spike_in;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            v_q     <= v_d;
            spk_q   <= spk_d;
            cnt_q   <= cnt_d;
        end
    end

    assign spike_out   = spk_q;
    assign membrane    = v_q;
    assign refractory  = state_q == S_REF;
    assign spike_count = cnt_q;
endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: vector table, corner sequences and a randomized run against a behavioural model.
module tb_lif_neuron;
`ifdef LIF_INHIBIT_EN
    localparam bit INH = 1'b1;
`else
    localparam bit INH = 1'b0;
`endif

    typedef struct {
        logic        e;
        logic [3:0]  s;
        logic [15:0] w;
        logic [7:0]  m;
        logic        so;
        logic        rf;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0, inh = 1'b0;
    logic [3:0]  spk = '0;
    logic [15:0] w = '0;
    logic so, rf, so2, rf2;
    logic [7:0] mem, cnt, mem2, cnt2;

    int passed = 0, total = 0;
    int m_v, m_ref, m_cnt, m_spk;
    logic [3:0] m_prev;
    logic m_iprev;
    vec_t tbl[13];

    always #5 clk = ~clk;

    lif_neuron u (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spk), .weight_in(w),
`ifdef LIF_INHIBIT_EN
        .inh_spike_in(inh),
`endif
        .spike_out(so), .membrane(mem), .refractory(rf), .spike_count(cnt));

    lif_neuron #(.THRESHOLD(255)) u_sat (
        .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spk), .weight_in(w),
`ifdef LIF_INHIBIT_EN
        .inh_spike_in(inh),
`endif
        .spike_out(so2), .membrane(mem2), .refractory(rf2), .spike_count(cnt2));

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0d, expected %0d", n, a, e);
    endtask

    task automatic model_reset();
        m_v = 0; m_ref = 0; m_cnt = 0; m_spk = 0; m_prev = '0; m_iprev = 1'b0;
    endtask

    // Reference: refractory tracked as "enabled cycles remaining", potential as a plain integer.
    task automatic model(input logic e, input logic [3:0] s, input logic [15:0] ww, input logic ih);
        int t;
        logic [3:0] ev;
        logic iev;
        ev = s & ~m_prev;
        iev = ih & ~m_iprev;
        m_prev = s;
        m_iprev = ih;
        if (!e) m_spk = 0;
        else if (m_ref > 0) begin
            m_ref--;
            m_spk = 0;
        end else begin
            t = m_v - m_v / 8;
            for (int i = 0; i < 4; i++) if (ev[i]) t += int'(ww[i*4 +: 4]);
            if (INH && iev) t -= 8;
            t = t < 0 ? 0 : (t > 255 ? 255 : t);
            if (t >= 64) begin
                m_v = 0; m_spk = 1; m_cnt = (m_cnt + 1) % 256; m_ref = 4;
            end else begin
                m_v = t; m_spk = 0;
            end
        end
    endtask

    task automatic step(input logic e, input logic [3:0] s, input logic [15:0] ww, input logic ih);
        ena = e; spk = s; w = ww; inh = ih;
        @(posedge clk);
        model(e, s, ww, ih);
        #1;
        chk("model membrane", mem, m_v);
        chk("model spike_out", so, m_spk);
        chk("model refractory", rf, m_ref > 0);
        chk("model spike_count", cnt, m_cnt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        spk = 4'($urandom); w = 16'($urandom); ena = 1'($urandom); inh = 1'($urandom);
        model_reset();
        #1;
        chk("reset spike_out", so, 0);
        chk("reset membrane", mem, 0);
        chk("reset refractory", rf, 0);
        chk("reset spike_count", cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset held membrane", mem, 0);
        chk("reset held sat membrane", mem2, 0);
        spk = '0; ena = 1'b0; inh = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int sat_exp[6];
        sat_exp = '{60, 113, 159, 200, 235, 250};
        tbl[0]  = '{1'b1, 4'h1, 16'h000A, 8'd10, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'h0, 16'h000A, 8'd9,  1'b0, 1'b0};
        tbl[2]  = '{1'b1, 4'h0, 16'h000A, 8'd8,  1'b0, 1'b0};
        tbl[3]  = '{1'b1, 4'h0, 16'h000A, 8'd7,  1'b0, 1'b0};
        tbl[4]  = '{1'b1, 4'h0, 16'h000A, 8'd7,  1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4'h1, 16'h000A, 8'd17, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'h1, 16'h000A, 8'd15, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'h1, 16'h000A, 8'd14, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'h1, 16'h000A, 8'd13, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'h1, 16'h000A, 8'd12, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 4'h0, 16'h000A, 8'd11, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'h1, 16'h000A, 8'd11, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 4'h1, 16'h000A, 8'd10, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].e, tbl[i].s, tbl[i].w, 1'b0);
            chk($sformatf("vec%0d membrane", i), mem, tbl[i].m);
            chk($sformatf("vec%0d spike_out", i), so, tbl[i].so);
            chk($sformatf("vec%0d refractory", i), rf, tbl[i].rf);
        end

        do_reset();
        step(1'b1, 4'hF, 16'hFFFF, 1'b0);
        chk("fire first sum", mem, 60);
        step(1'b0, 4'h0, 16'hFFFF, 1'b0);
        step(1'b1, 4'hF, 16'hFFFF, 1'b0);
        chk("fire spike_out", so, 1);
        chk("fire membrane", mem, 0);
        chk("fire refractory", rf, 1);
        chk("fire spike_count", cnt, 1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, (k % 2 == 1) ? 4'hF : 4'h0, 16'hFFFF, 1'b0);
            chk($sformatf("refrac%0d refractory", k), rf, k < 3 ? 1 : 0);
            chk($sformatf("refrac%0d membrane", k), mem, 0);
            chk($sformatf("refrac%0d spike_out", k), so, 0);
        end
        step(1'b1, 4'h0, 16'hFFFF, 1'b0);
        chk("post refrac membrane", mem, 0);
        chk("post refrac spike_count", cnt, 1);

        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 4'hF, k == 5 ? 16'hBBBB : 16'hFFFF, 1'b0);
            chk($sformatf("sat ramp%0d membrane", k), mem2, sat_exp[k]);
            step(1'b0, 4'h0, 16'hFFFF, 1'b0);
        end
        step(1'b1, 4'hF, 16'hFFFF, 1'b0);
        chk("sat spike_out", so2, 1);
        chk("sat membrane", mem2, 0);
        chk("sat spike_count", cnt2, 1);

        do_reset();
        step(1'b1, 4'hF, 16'hFFFF, 1'b0);
        step(1'b0, 4'h0, 16'hFFFF, 1'b0);
        step(1'b1, 4'hF, 16'hFFFF, 1'b0);
        step(1'b1, 4'h0, 16'hFFFF, 1'b0);
        chk("pre-reset refractory", rf, 1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async reset refractory", rf, 0);
        chk("async reset membrane", mem, 0);
        chk("async reset spike_count", cnt, 0);
        @(posedge clk);
        #1 spk = '0; ena = 1'b0; rst_n = 1'b1;
        step(1'b1, 4'h1, 16'h0005, 1'b0);
        chk("after reset integrate", mem, 5);
`ifdef LIF_INHIBIT_EN
        step(1'b1, 4'h0, 16'h0000, 1'b1);
        chk("inhibit clamp", mem, 0);
`endif

        for (int k = 0; k < 2000; k++)
            step($urandom_range(0, 9) != 0, 4'($urandom), 16'($urandom), 1'($urandom));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
